cla_adder_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. It builds a two-level lookahead tree from 4-bit group units, supports add, subtract, add-with-carry and subtract-with-borrow, and returns sum plus flags. A valid/ready handshake on both sides lets the ALU issue stage and the writeback stage stall it independently.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/cla_group4.sv | 34 +++
 rtl/cla_adder_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU opcode encodings and carry-lookahead group size.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Adder/subtractor opcodes; bit 0 selects inversion of operand B
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } alu_op_t;

  // Bits per lookahead group, and groups per second-level block
  localparam int CLA_GROUP = 4;

endpackage

`default_nettype wire

// File: rtl/cla_group4.sv
// ============================================================================
//  Module   : cla_group4
//  Purpose  : 4-wide carry-lookahead unit. Produces the three internal carries
//             from a carry-in, plus group propagate/generate. Used both on
//             bit-level p/g and on group-level P/G.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_group4
  import alu_pkg::*;
(
  input  logic [CLA_GROUP-1:0] i_p,
  input  logic [CLA_GROUP-1:0] i_g,
  input  logic                 i_cin,
  output logic [CLA_GROUP-1:1] o_c,
  output logic                 o_pg,
  output logic                 o_gg
);

  // Flattened lookahead equations; group P/G are independent of i_cin
  always_comb begin
    o_c[1] = i_g[0] | (i_p[0] & i_cin);
    o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
           | (i_p[2] & i_p[1] & i_p[0] & i_cin);
    o_pg   = &i_p;
    o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
           | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  end

endmodule

`default_nettype wire

// File: rtl/cla_adder_pipe.sv
// ============================================================================
//  Module   : cla_adder_pipe
//  Purpose  : Pipelined two-level carry-lookahead adder/subtractor with
//             valid/ready handshakes. Stage A: operand prep, bit p/g, group
//             P/G. Optional register (PIPE=1). Stage B: block lookahead, group
//             carries, sum and flags into the output register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_adder_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = WIDTH / CLA_GROUP;                  // groups
  localparam int NB = (NG + CLA_GROUP - 1) / CLA_GROUP;   // second-level blocks

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 8..64");
  end
  if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
    $error("cla_adder_pipe: PIPE must be 0 or 1");
  end

  // Every stage holds while the output register is full and not taken
  logic w_stall;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------- Stage A: operand preparation and group P/G ----------------
  alu_op_t          w_op;
  logic [WIDTH-1:0] w_bx, w_pa, w_ga;
  logic             w_c0a;
  logic [NG-1:0]    w_gpa, w_gga;
  logic [3*NG-1:0]  w_unused_ca;

  assign w_op = alu_op_t'(in_op);
  assign w_bx = in_b ^ {WIDTH{in_op[0]}};
  assign w_pa = in_a ^ w_bx;
  assign w_ga = in_a & w_bx;

  // Carry-in per opcode; SUBB treats in_cin as an active-high borrow
  always_comb begin
    w_c0a = 1'b0;
    case (w_op)
      OP_ADD:  w_c0a = 1'b0;
      OP_SUB:  w_c0a = 1'b1;
      OP_ADDC: w_c0a = in_cin;
      OP_SUBB: w_c0a = ~in_cin;
      default: w_c0a = 1'b0;
    endcase
  end

  // Group P/G only; the carries of these units are recomputed in stage B
  for (genvar j = 0; j < NG; j++) begin : g_gen
    cla_group4 u_gen (
      .i_p   (w_pa[CLA_GROUP*j +: CLA_GROUP]),
      .i_g   (w_ga[CLA_GROUP*j +: CLA_GROUP]),
      .i_cin (1'b0),
      .o_c   (w_unused_ca[3*j +: 3]),
      .o_pg  (w_gpa[j]),
      .o_gg  (w_gga[j])
    );
  end

  // ---------------- Optional mid-pipe register ----------------
  logic             w_vb, w_c0b;
  logic [WIDTH-1:0] w_pb, w_gb;
  logic [NG-1:0]    w_gpb, w_ggb;

  if (PIPE == 1) begin : g_pipe
    logic             r_mid_valid, r_mid_c0;
    logic [WIDTH-1:0] r_mid_p, r_mid_g;
    logic [NG-1:0]    r_mid_gp, r_mid_gg;

    // Capture stage A on input transfer; bubbles advance as valid=0
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mid_valid <= 1'b0;
        r_mid_c0    <= 1'b0;
        r_mid_p     <= '0;
        r_mid_g     <= '0;
        r_mid_gp    <= '0;
        r_mid_gg    <= '0;
      end else if (!w_stall) begin
        r_mid_valid <= in_valid;
        if (in_valid) begin
          r_mid_c0 <= w_c0a;
          r_mid_p  <= w_pa;
          r_mid_g  <= w_ga;
          r_mid_gp <= w_gpa;
          r_mid_gg <= w_gga;
        end
      end
    end

    assign w_vb  = r_mid_valid;
    assign w_c0b = r_mid_c0;
    assign w_pb  = r_mid_p;
    assign w_gb  = r_mid_g;
    assign w_gpb = r_mid_gp;
    assign w_ggb = r_mid_gg;
  end else begin : g_nopipe
    assign w_vb  = in_valid;
    assign w_c0b = w_c0a;
    assign w_pb  = w_pa;
    assign w_gb  = w_ga;
    assign w_gpb = w_gpa;
    assign w_ggb = w_gga;
  end

  // ---------------- Stage B: carry resolution ----------------
  logic [CLA_GROUP*NB-1:0] w_gp_pad, w_gg_pad;
  logic [NB-1:0]           w_bp, w_bg;
  logic [NB:0]             w_bc;          // carry into each block
  logic [CLA_GROUP*NB:0]   w_gc;          // carry into each (padded) group
  logic [WIDTH:0]          w_c;           // carry into each bit
  logic [NG-1:0]           w_unused_pr, w_unused_gr;
  logic                    w_unused_gc;

  // Unused upper groups propagate nothing and generate nothing
  always_comb begin
    w_gp_pad         = '0;
    w_gg_pad         = '0;
    w_gp_pad[NG-1:0] = w_gpb;
    w_gg_pad[NG-1:0] = w_ggb;
  end

  // Ripple between top-level blocks of four groups
  always_comb begin
    w_bc    = '0;
    w_bc[0] = w_c0b;
    for (int k = 0; k < NB; k++) begin
      w_bc[k+1] = w_bg[k] | (w_bp[k] & w_bc[k]);
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_lvl2
    cla_group4 u_blk (
      .i_p   (w_gp_pad[CLA_GROUP*k +: CLA_GROUP]),
      .i_g   (w_gg_pad[CLA_GROUP*k +: CLA_GROUP]),
      .i_cin (w_bc[k]),
      .o_c   (w_gc[CLA_GROUP*k+1 +: 3]),
      .o_pg  (w_bp[k]),
      .o_gg  (w_bg[k])
    );
    assign w_gc[CLA_GROUP*k] = w_bc[k];
  end
  assign w_gc[CLA_GROUP*NB] = w_bc[NB];
  assign w_unused_gc        = ^w_gc;

  for (genvar j = 0; j < NG; j++) begin : g_lvl1
    cla_group4 u_res (
      .i_p   (w_pb[CLA_GROUP*j +: CLA_GROUP]),
      .i_g   (w_gb[CLA_GROUP*j +: CLA_GROUP]),
      .i_cin (w_gc[j]),
      .o_c   (w_c[CLA_GROUP*j+1 +: 3]),
      .o_pg  (w_unused_pr[j]),
      .o_gg  (w_unused_gr[j])
    );
    assign w_c[CLA_GROUP*j] = w_gc[j];
  end
  assign w_c[WIDTH] = w_gc[NG];

  logic [WIDTH-1:0] w_sum;
  assign w_sum = w_pb ^ w_c[WIDTH-1:0];

  // ---------------- Output register ----------------
  logic             r_out_valid, r_out_cout, r_out_ovf, r_out_zero;
  logic [WIDTH-1:0] r_out_sum;

  // Load result when not stalled; data only changes on a valid result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= w_vb;
      if (w_vb) begin
        r_out_sum  <= w_sum;
        r_out_cout <= w_c[WIDTH];
        r_out_ovf  <= w_c[WIDTH] ^ w_c[WIDTH-1];
        r_out_zero <= ~|w_sum;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
// ============================================================================
//  Module   : tb_cla_adder_pipe
//  Purpose  : Self-checking bench for cla_adder_pipe (32-bit/PIPE=1 and
//             64-bit/PIPE=0 instances) with a queue-based scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla_adder_pipe;
  import alu_pkg::*;

  localparam int W0 = 32, P0 = 1;
  localparam int W1 = 64, P1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          d0_iv, d0_ir, d0_ov, d0_or, d0_cin, d0_co, d0_of, d0_z;
  logic [1:0]    d0_op;
  logic [W0-1:0] d0_a, d0_b, d0_s;
  logic          d1_iv, d1_ir, d1_ov, d1_or, d1_cin, d1_co, d1_of, d1_z;
  logic [1:0]    d1_op;
  logic [W1-1:0] d1_a, d1_b, d1_s;

  cla_adder_pipe #(.WIDTH(W0), .PIPE(P0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(d0_iv), .in_ready(d0_ir), .in_a(d0_a), .in_b(d0_b),
    .in_op(d0_op), .in_cin(d0_cin), .out_valid(d0_ov), .out_ready(d0_or), .out_sum(d0_s),
    .out_cout(d0_co), .out_ovf(d0_of), .out_zero(d0_z));

  cla_adder_pipe #(.WIDTH(W1), .PIPE(P1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_iv), .in_ready(d1_ir), .in_a(d1_a), .in_b(d1_b),
    .in_op(d1_op), .in_cin(d1_cin), .out_valid(d1_ov), .out_ready(d1_or), .out_sum(d1_s),
    .out_cout(d1_co), .out_ovf(d1_of), .out_zero(d1_z));

  typedef struct packed { logic [63:0] sum; logic cout; logic ovf; logic zero; } res_t;
  typedef struct { res_t r; int cyc; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; logic cin; res_t r; } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   lat_on [2];
  bit   rr     [2];
  bit   hp     [2];
  res_t held   [2];
  int   stall_cnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic [63:0] s, input logic c, input logic o, input logic z);
    res_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z;
    return r;
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Behavioural reference: plain wide addition, signed overflow from operand signs
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op, input logic cin, input int w);
    logic [63:0] am, bx, s;
    logic [64:0] full;
    logic        c0, ovf;
    am = a & mask(w);
    bx = (op[0] ? ~b : b) & mask(w);
    case (op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      2'b10:   c0 = cin;
      default: c0 = ~cin;
    endcase
    full = {1'b0, am} + {1'b0, bx} + {64'd0, c0};
    s    = full[63:0] & mask(w);
    ovf  = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
    return mk(s, full[w], ovf, s == 64'd0);
  endfunction

  function automatic logic [63:0] rnd(input int w);
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask(w);
      2:       return (mask(w) >> 1) + 64'd1;
      3:       return mask(w) >> 1;
      default: return {$urandom, $urandom} & mask(w);
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Output-side checks for one DUT, called at each falling edge
  task automatic mon(input int s, input int pipe, input logic v, input logic rdy,
                     input logic ir, input res_t o);
    exp_t e;
    int   sz;
    chk($sformatf("in_ready%0d", s), {127'd0, ir}, {127'd0, ~(v & ~rdy)});
    if (hp[s]) chk($sformatf("stall_hold%0d", s), 128'(o), 128'(held[s]));
    hp[s]   = v & ~rdy;
    held[s] = o;
    if (v && !rdy) stall_cnt[s]++;
    if (v && rdy) begin
      sz = (s == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out%0d: got %h expected no result", s, o);
      end else begin
        if (s == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("result%0d", s), 128'(o), 128'(e.r));
        if (lat_on[s]) chk($sformatf("latency%0d", s), 128'(cyc - e.cyc), 128'(1 + pipe));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hp[0] = 1'b0; hp[1] = 1'b0;
    end else begin
      mon(0, P0, d0_ov, d0_or, d0_ir, {32'd0, d0_s, d0_co, d0_of, d0_z});
      mon(1, P1, d1_ov, d1_or, d1_ir, {d1_s, d1_co, d1_of, d1_z});
    end
  end

  // Random consumer back-pressure (70% ready)
  always @(posedge clk) begin
    #1;
    if (rr[0]) d0_or = ($urandom_range(0, 9) < 7);
    if (rr[1]) d1_or = ($urandom_range(0, 9) < 7);
  end

  task automatic issue(input int s, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic cin, input res_t r);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    if (s == 0) begin d0_a = a[31:0]; d0_b = b[31:0]; d0_op = op; d0_cin = cin; d0_iv = 1'b1; end
    else        begin d1_a = a;       d1_b = b;       d1_op = op; d1_cin = cin; d1_iv = 1'b1; end
    #1;
    n = 0;
    while (((s == 0) ? d0_ir : d1_ir) !== 1'b1 && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout%0d: got in_ready=0 expected 1 within 200 cycles", s);
    end else begin
      e.r = r; e.cyc = cyc;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Bubble with scrambled operands, which must be ignored
  task automatic idle(input int s);
    @(posedge clk); #1;
    if (s == 0) begin d0_iv = 1'b0; d0_a = $urandom; d0_b = $urandom; d0_op = 2'($urandom); end
    else        begin d1_iv = 1'b0; d1_a = {$urandom, $urandom}; d1_b = {$urandom, $urandom}; end
  endtask

  task automatic drain(input int s);
    int n;
    n = 0;
    while (((s == 0) ? q0.size() : q1.size()) > 0 && n < 500) begin
      @(posedge clk); n++;
    end
    chk($sformatf("drain%0d", s), 128'((s == 0) ? q0.size() : q1.size()), 128'(0));
  endtask

  task automatic sweep(input int s, input int n);
    logic [63:0] a, b;
    logic [1:0]  op;
    logic        c;
    int          w;
    w = (s == 0) ? W0 : W1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) idle(s);
      else begin
        a = rnd(w); b = rnd(w); op = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
        issue(s, a, b, op, c, model(a, b, op, c, w));
      end
    end
    idle(s);
  endtask

  vec_t tbl [15];

  initial begin
    logic [63:0] a, b;
    logic [1:0]  op;
    logic        c;
    int          st0;

    tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, OP_ADD,  1'b0, mk(64'h0,           1'b1, 1'b0, 1'b1)};
    tbl[1]  = '{32'h8000_0000, 32'h0000_0001, OP_SUB,  1'b0, mk(64'h7FFF_FFFF,   1'b1, 1'b1, 1'b0)};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0000, OP_ADDC, 1'b1, mk(64'h8000_0000,   1'b0, 1'b1, 1'b0)};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, OP_SUBB, 1'b1, mk(64'hFFFF_FFFF,   1'b0, 1'b0, 1'b0)};
    tbl[4]  = '{32'h0000_0001, 32'h0000_0001, OP_ADD,  1'b0, mk(64'h2,           1'b0, 1'b0, 1'b0)};
    tbl[5]  = '{32'h0000_0005, 32'h0000_0005, OP_SUB,  1'b0, mk(64'h0,           1'b1, 1'b0, 1'b1)};
    tbl[6]  = '{32'h0000_0003, 32'h0000_0005, OP_SUB,  1'b0, mk(64'hFFFF_FFFE,   1'b0, 1'b0, 1'b0)};
    tbl[7]  = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,  1'b0, mk(64'h8000_0000,   1'b0, 1'b1, 1'b0)};
    tbl[8]  = '{32'h1234_5678, 32'h1111_1111, OP_ADDC, 1'b0, mk(64'h2345_6789,   1'b0, 1'b0, 1'b0)};
    tbl[9]  = '{32'h0000_000A, 32'h0000_0003, OP_SUBB, 1'b0, mk(64'h7,           1'b1, 1'b0, 1'b0)};
    tbl[10] = '{32'h8000_0000, 32'h8000_0000, OP_ADD,  1'b0, mk(64'h0,           1'b1, 1'b1, 1'b1)};
    tbl[11] = '{32'h0000_000F, 32'h0000_0001, OP_ADD,  1'b1, mk(64'h10,          1'b0, 1'b0, 1'b0)};
    tbl[12] = '{32'h0000_0000, 32'h0000_0000, OP_SUB,  1'b1, mk(64'h0,           1'b1, 1'b0, 1'b1)};
    tbl[13] = '{32'h0000_FFFF, 32'h0000_0001, OP_ADD,  1'b0, mk(64'h0001_0000,   1'b0, 1'b0, 1'b0)};
    tbl[14] = '{32'h8000_0000, 32'h0000_0000, OP_SUBB, 1'b1, mk(64'h7FFF_FFFF,   1'b1, 1'b1, 1'b0)};

    d0_iv = 0; d0_a = 0; d0_b = 0; d0_op = 0; d0_cin = 0; d0_or = 1;
    d1_iv = 0; d1_a = 0; d1_b = 0; d1_op = 0; d1_cin = 0; d1_or = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset0", {d0_ov, d0_s, d0_co, d0_of, d0_z, d0_ir}, {1'b0, 32'd0, 3'b000, 1'b1});
    chk("reset1", {d1_ov, d1_s, d1_co, d1_of, d1_z, d1_ir}, {1'b0, 64'd0, 3'b000, 1'b1});

    // Directed vectors, back to back, with latency checking
    lat_on[0] = 1'b1;
    for (int i = 0; i < 15; i++)
      issue(0, {32'd0, tbl[i].a}, {32'd0, tbl[i].b}, tbl[i].op, tbl[i].cin, tbl[i].r);
    idle(0);
    drain(0);
    lat_on[0] = 1'b0;

    // Back-pressure: consumer stalls for four cycles mid-stream
    st0 = stall_cnt[0];
    fork
      begin
        repeat (3) @(posedge clk);
        #1 d0_or = 1'b0;
        repeat (4) @(posedge clk);
        #1 d0_or = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      a = rnd(W0); b = rnd(W0); op = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
      issue(0, a, b, op, c, model(a, b, op, c, W0));
    end
    idle(0);
    drain(0);
    chk("bp_stall_cycles", 128'(stall_cnt[0] - st0), 128'(4));

    // Reset with two operations in flight
    issue(0, 64'h1, 64'h2, OP_ADD, 1'b0, mk(64'h3, 1'b0, 1'b0, 1'b0));
    issue(0, 64'h5, 64'h6, OP_ADD, 1'b0, mk(64'hB, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1; d0_iv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    chk("midreset0", {d0_ov, d0_s, d0_co, d0_of, d0_z, d0_ir}, {1'b0, 32'd0, 3'b000, 1'b1});
    repeat (6) @(posedge clk);
    chk("midreset_q0", 128'(q0.size()), 128'(0));

    // 64-bit no-pipe instance: boundaries with latency checking
    lat_on[1] = 1'b1;
    issue(1, {64{1'b1}}, 64'd1, OP_ADD, 1'b0, mk(64'd0, 1'b1, 1'b0, 1'b1));
    issue(1, 64'h8000_0000_0000_0000, 64'd1, OP_SUB, 1'b0,
          mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0));
    issue(1, 64'd0, 64'd0, OP_SUBB, 1'b1, mk({64{1'b1}}, 1'b0, 1'b0, 1'b0));
    issue(1, 64'h0000_0000_FFFF_FFFF, 64'd1, OP_ADDC, 1'b1,
          mk(64'h0000_0001_0000_0001, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      a = rnd(W1); b = rnd(W1); op = 2'($urandom_range(0, 3)); c = 1'($urandom_range(0, 1));
      issue(1, a, b, op, c, model(a, b, op, c, W1));
    end
    idle(1);
    drain(1);
    lat_on[1] = 1'b0;

    // Random streams with random back-pressure on both instances
    rr[0] = 1'b1; rr[1] = 1'b1;
    fork
      sweep(0, 3000);
      sweep(1, 3000);
    join
    rr[0] = 1'b0; rr[1] = 1'b0;
    @(posedge clk); #2;
    d0_or = 1'b1; d1_or = 1'b1;
    drain(0);
    drain(1);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
